// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample indices and
// frame constants. Also used by the transmit-side tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_BRKWAIT = 3'd4
  } rx_state_e;

  // Oversample positions inside one bit (8 ticks per bit)
  localparam logic [2:0] SMP_A    = 3'd3;
  localparam logic [2:0] SMP_B    = 3'd4;
  localparam logic [2:0] SMP_C    = 3'd5;
  localparam logic [2:0] LAST_SUB = 3'd7;

  localparam int NDATABITS  = 8;
  localparam int OVERSAMPLE = 8;

  // 2-of-3 majority vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bitx8ce_gen.sv
// Phase-accumulator tick generator: one-clk pulse at 8x the bit rate.
// Average rate is exact; individual tick spacing jitters by at most 1 clk.
module uart_bitx8ce_gen
  import uart_pkg::*;
#(
  parameter int SYSCLKFRQ = 12000000,
  parameter int BITCLKFRQ = 115200
) (
  input  logic clk,
  input  logic rst_n,
  output logic bitx8ce
);

  localparam logic [32:0] INC  = 33'(OVERSAMPLE * BITCLKFRQ);
  localparam logic [32:0] MODV = 33'(SYSCLKFRQ);

  logic [31:0] acc_q, acc_d;
  logic        tick_q, tick_d;
  logic [32:0] sum;

  // Accumulate; wrap by SYSCLKFRQ and fire a tick on each wrap
  always_comb begin
    sum    = {1'b0, acc_q} + INC;
    acc_d  = sum[31:0];
    tick_d = 1'b0;
    if (sum >= MODV) begin
      acc_d  = 32'(sum - MODV);
      tick_d = 1'b1;
    end
  end

  // Accumulator and registered tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign bitx8ce = tick_q;

endmodule

// File: rtl/uart_rx_m.sv
// Standalone 8N1 UART receiver, 8x oversampling with 3-sample majority vote.
// Strobes bytercvd on a good stop bit, framingerr on a low stop bit.
module uart_rx_m
  import uart_pkg::*;
#(
  parameter int SYSCLKFRQ                = 12000000,
  parameter int BITCLKFRQ                = 115200,
  parameter int ACCEPTEDERROR_IN_PERCENT = 2,
  parameter int HASRXBYTEREGISTER        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxpin,
  output logic [7:0] q,
  output logic       bytercvd,
  output logic       framingerr,
  output logic       rxbusy,
  output logic       bitx8ce
);

  // Reject clock/baud combinations that cannot be oversampled cleanly
  if (SYSCLKFRQ < 16 * BITCLKFRQ) begin : g_chk_rate
    $error("uart_rx_m: SYSCLKFRQ must be at least 16*BITCLKFRQ");
  end
  if ((64'(100) * 64'(OVERSAMPLE) * 64'(BITCLKFRQ)) / 64'(SYSCLKFRQ) >
      64'(ACCEPTEDERROR_IN_PERCENT) * 64'(OVERSAMPLE)) begin : g_chk_err
    $error("uart_rx_m: tick jitter exceeds ACCEPTEDERROR_IN_PERCENT");
  end

  localparam logic [2:0] LAST_BIT = 3'(NDATABITS - 1);

  logic tick;

  uart_bitx8ce_gen #(
    .SYSCLKFRQ(SYSCLKFRQ),
    .BITCLKFRQ(BITCLKFRQ)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .bitx8ce(tick)
  );

  logic       sync1_q, sync2_q, rxs;
  rx_state_e  state_q, state_d;
  logic [2:0] sub_q, sub_d;
  logic [2:0] nbit_q, nbit_d;
  logic [7:0] sh_q, sh_d;
  logic [1:0] smp_q, smp_d;
  logic [7:0] rxq_q, rxq_d;
  logic       bytercvd_q, bytercvd_d;
  logic       framingerr_q, framingerr_d;
  logic       v;

  // Two-flop synchroniser, idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxpin;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // Vote over the samples at sub 3 and 4 plus the live level at sub 5
  assign v = maj3(smp_q[1], smp_q[0], rxs);

  // Receive FSM: all state/counter movement happens on oversample ticks
  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    nbit_d       = nbit_q;
    sh_d         = sh_q;
    smp_d        = smp_q;
    rxq_d        = rxq_q;
    bytercvd_d   = 1'b0;
    framingerr_d = 1'b0;
    if (tick) begin
      if (sub_q == SMP_A) smp_d[1] = rxs;
      if (sub_q == SMP_B) smp_d[0] = rxs;
      unique case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d = ST_START;
            sub_d   = 3'd1;
          end
        end
        ST_START: begin
          sub_d = sub_q + 3'd1;
          if (sub_q == SMP_C && v) begin
            // start bit did not hold low: treat as a glitch
            state_d = ST_IDLE;
            sub_d   = 3'd0;
          end else if (sub_q == LAST_SUB) begin
            state_d = ST_DATA;
            sub_d   = 3'd0;
            nbit_d  = 3'd0;
          end
        end
        ST_DATA: begin
          sub_d = sub_q + 3'd1;  // wraps 7 -> 0 at each bit boundary
          if (sub_q == SMP_C) sh_d = {v, sh_q[7:1]};
          if (sub_q == LAST_SUB) begin
            nbit_d = nbit_q + 3'd1;
            if (nbit_q == LAST_BIT) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          sub_d = sub_q + 3'd1;
          if (sub_q == SMP_C) begin
            sub_d = 3'd0;
            if (v) begin
              // leave early so a short stop bit still catches the next start
              if (HASRXBYTEREGISTER != 0) rxq_d = sh_q;
              bytercvd_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              framingerr_d = 1'b1;
              state_d      = ST_BRKWAIT;
            end
          end
        end
        ST_BRKWAIT: begin
          if (rxs) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, counters, shift and holding registers, strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sub_q        <= '0;
      nbit_q       <= '0;
      sh_q         <= '0;
      smp_q        <= '0;
      rxq_q        <= '0;
      bytercvd_q   <= 1'b0;
      framingerr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      nbit_q       <= nbit_d;
      sh_q         <= sh_d;
      smp_q        <= smp_d;
      rxq_q        <= rxq_d;
      bytercvd_q   <= bytercvd_d;
      framingerr_q <= framingerr_d;
    end
  end

  assign q          = (HASRXBYTEREGISTER != 0) ? rxq_q : sh_q;
  assign bytercvd   = bytercvd_q;
  assign framingerr = framingerr_q;
  assign rxbusy     = (state_q != ST_IDLE);
  assign bitx8ce    = tick;

endmodule

// File: tb/tb_uart_rx_m.sv
// Bench for uart_rx_m: drives 8N1 frames on rxpin, and a frame-level model
// (queue of expected byte / framing-error events) checks every strobe, its
// latency from the line falling edge, and that q only moves on good frames.
module tb_uart_rx_m;

  localparam int BT = 1250;  // nominal bit time: 104.1667 clk of 12 units

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxpin;
  logic [7:0] q_a, q_b;
  logic       byt_a, byt_b, fe_a, fe_b, busy_a, busy_b, tick_a, tick_b;

  always #6 clk = ~clk;

  uart_rx_m #(.HASRXBYTEREGISTER(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rxpin(rxpin), .q(q_a), .bytercvd(byt_a),
    .framingerr(fe_a), .rxbusy(busy_a), .bitx8ce(tick_a)
  );

  uart_rx_m #(.HASRXBYTEREGISTER(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rxpin(rxpin), .q(q_b), .bytercvd(byt_b),
    .framingerr(fe_b), .rxbusy(busy_b), .bitx8ce(tick_b)
  );

  typedef struct {
    logic       err;
    logic [7:0] d;
    longint     fall;
  } ev_t;

  ev_t    qa[$];
  ev_t    qb[$];
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  int     n_byte_a = 0;
  int     n_ferr_a = 0;

  logic [7:0] rate_tab [16] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'h3C,
                                8'hC3, 8'h12, 8'h34, 8'hEF, 8'h96, 8'h69, 8'hF0, 8'h0F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One 8N1 frame; the expected event is queued at the falling edge
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int bt,
                            input bit expect_ev);
    ev_t e;
    if (expect_ev) begin
      e.err  = ~stopv;
      e.d    = d;
      e.fall = cyc;
      qa.push_back(e);
      qb.push_back(e);
    end
    rxpin = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rxpin = d[i];
      #(bt);
    end
    rxpin = stopv;
    #(bt);
  endtask

  task automatic drained(input string name);
    #(BT);
    chk({name, "_drain_a"}, qa.size() == 0, qa.size(), 0);
    chk({name, "_drain_b"}, qb.size() == 0, qb.size(), 0);
  endtask

  // Compare process: strobes against the event queue, q hold rule, tick spacing
  initial begin : compare
    ev_t        e;
    logic [7:0] mq_a;
    longint     last_tick;
    longint     lat;
    mq_a      = 8'h00;
    last_tick = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq_a      = 8'h00;
        last_tick = -1;
      end else begin
        if (tick_a) begin
          if (last_tick >= 0)
            chk("tick_gap", (cyc - last_tick) == 13 || (cyc - last_tick) == 14,
                cyc - last_tick, 13);
          last_tick = cyc;
        end
        if (byt_a || fe_a) begin
          chk("strobe_excl_a", !(byt_a && fe_a), {byt_a, fe_a}, 0);
          if (byt_a) n_byte_a++;
          if (fe_a) n_ferr_a++;
          if (qa.size() == 0) begin
            chk("unexpected_strobe_a", 1'b0, {byt_a, fe_a}, 0);
          end else begin
            e   = qa.pop_front();
            lat = cyc - e.fall;
            chk("latency_a", lat >= 1000 && lat <= 1025, lat, 1005);
            chk("kind_a", fe_a == e.err, fe_a, e.err);
            if (byt_a && !e.err) mq_a = e.d;
          end
        end
        chk("q_hold_a", q_a == mq_a, q_a, mq_a);
        if (byt_b || fe_b) begin
          chk("strobe_excl_b", !(byt_b && fe_b), {byt_b, fe_b}, 0);
          if (qb.size() == 0) begin
            chk("unexpected_strobe_b", 1'b0, {byt_b, fe_b}, 0);
          end else begin
            e = qb.pop_front();
            chk("kind_b", fe_b == e.err, fe_b, e.err);
            if (byt_b && !e.err) chk("q_bypass_b", q_b == e.d, q_b, e.d);
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    rxpin = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_q_a", q_a == 8'h00, q_a, 0);
    chk("rst_q_b", q_b == 8'h00, q_b, 0);
    chk("rst_strobes", {byt_a, fe_a, byt_b, fe_b} == 4'b0, {byt_a, fe_a, byt_b, fe_b}, 0);
    chk("rst_busy", {busy_a, busy_b} == 2'b0, {busy_a, busy_b}, 0);
    chk("rst_tick", {tick_a, tick_b} == 2'b0, {tick_a, tick_b}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Tick rate: 6000 clk * 921600/12e6 = 460.8 ticks
    n = 0;
    repeat (6000) begin
      @(negedge clk);
      if (tick_a) n++;
    end
    chk("tick_count", n == 460 || n == 461, n, 461);

    // Basic back-to-back frames
    send_frame(8'hC1, 1'b1, BT, 1'b1);
    send_frame(8'h4E, 1'b1, BT, 1'b1);
    drained("basic");
    chk("basic_nbytes", n_byte_a == 2, n_byte_a, 2);
    chk("basic_q", q_a == 8'h4E, q_a, 8'h4E);
    chk("basic_noferr", n_ferr_a == 0, n_ferr_a, 0);

    // Glitch: 39 clk low on an idle line
    @(posedge clk);
    #1 rxpin = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_busy", busy_a == 1'b1, busy_a, 1);
    repeat (9) @(posedge clk);
    #1 rxpin = 1'b1;
    repeat (79) @(negedge clk);
    chk("glitch_idle", busy_a == 1'b0, busy_a, 0);
    drained("glitch");

    // Framing error followed by a long break, then a good frame
    send_frame(8'h55, 1'b0, BT, 1'b1);
    #(20 * BT);
    chk("brk_hold", busy_a == 1'b1, busy_a, 1);
    chk("ferr_count", n_ferr_a == 1, n_ferr_a, 1);
    chk("ferr_q_kept", q_a == 8'h4E, q_a, 8'h4E);
    rxpin = 1'b1;
    #(2 * BT);
    chk("brk_release", busy_a == 1'b0, busy_a, 0);
    send_frame(8'hA5, 1'b1, BT, 1'b1);
    drained("ferr");
    chk("after_ferr_q", q_a == 8'hA5, q_a, 8'hA5);

    // Line rate +2% then -2%
    for (int i = 0; i < 16; i++) send_frame(rate_tab[i], 1'b1, 1225, 1'b1);
    drained("fast");
    for (int i = 0; i < 16; i++) send_frame(rate_tab[i], 1'b1, 1276, 1'b1);
    drained("slow");
    chk("rate_nbytes", n_byte_a == 35, n_byte_a, 35);

    // Reset during data bit 3 of 0xFF
    rxpin = 1'b0;
    #(BT);
    rxpin = 1'b1;
    #(3 * BT + BT / 2);
    @(posedge clk);
    #1;
    chk("mid_busy", busy_a == 1'b1, busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("async_q_a", q_a == 8'h00, q_a, 0);
    chk("async_q_b", q_b == 8'h00, q_b, 0);
    chk("async_busy", busy_a == 1'b0, busy_a, 0);
    chk("async_strobes", {byt_a, fe_a, tick_a} == 3'b0, {byt_a, fe_a, tick_a}, 0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b1;
    #(6 * BT);
    send_frame(8'h3C, 1'b1, BT, 1'b1);
    drained("rstmid");
    chk("after_rst_q", q_a == 8'h3C, q_a, 8'h3C);

    // Bypass: shift register visible mid-frame (after bits 0..4 of 0x81)
    fork
      send_frame(8'h81, 1'b1, BT, 1'b1);
      begin
        #(6 * BT + BT / 5);
        chk("bypass_midframe", q_b[7:3] == 5'b00001, q_b, 8'h08);
      end
    join
    drained("bypass");
    chk("bypass_q_b", q_b == 8'h81, q_b, 8'h81);
    chk("bypass_q_a", q_a == 8'h81, q_a, 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #(20_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
